// File: rtl/fetch_controller_if.sv
// Fetch controller bus: instruction memory port, redirect, decode queue head, status.
// Latency: n/a (signal bundle only).
// Backpressure: out_valid/out_ready handshake on the queue head; imem is combinational.
interface fetch_controller_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic [31:0] fetch_count;

    // The fetch controller drives the memory address, queue head and status.
    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output halted,
        output fetch_count
    );

    // Memory model and decode stage sit on the other side.
    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  halted,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch: walks PC through a combinational imem into a 2-entry {pc,instr} queue.
// Latency: 1 cycle from push to out_valid; redirect empties the queue and refetches next cycle.
// Backpressure: out_ready low lets the queue fill to 2, then PC stalls; redirect overrides all.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 512
) (
    input  logic               clk,
    input  logic               rst,
    fetch_controller_if.master bus
);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);
    localparam logic [31:0] PC_RESET  = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_count_q;
    logic [31:0] pc_mem_q  [2];
    logic [31:0] ins_mem_q [2];
    logic        wr_ptr_q, rd_ptr_q;
    logic [1:0]  cnt_q;

    logic        head_vld;
    logic        pop;
    logic        in_range;
    logic        fetch_en;
    logic        push;
    logic        halted;

    // Queue handshake and memory range qualification.
    always_comb begin
        head_vld = (cnt_q != 2'd0);
        pop      = head_vld && bus.out_ready && !bus.redirect_valid;
        in_range = (pc_q < MEM_LIMIT);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state: redirect wins everywhere; HALT is sticky otherwise.
    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid) begin
            state_d = FETCH;
        end else begin
            unique case (state_q)
                IDLE:    state_d = FETCH;
                FETCH:   state_d = in_range ? FETCH : HALT;
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: push only in FETCH with room (a same-cycle pop frees a slot).
    always_comb begin
        fetch_en = (state_q == FETCH);
        halted   = (state_q == HALT);
        push     = fetch_en && !bus.redirect_valid && in_range &&
                   ((cnt_q != 2'd2) || pop);
    end

    // Next PC: redirect target is word-aligned; otherwise advance on push.
    always_comb begin
        pc_d = pc_q;
        if (bus.redirect_valid) pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
        else if (push)          pc_d = pc_q + 32'd4;
    end

    // PC, queue pointers/occupancy and fetch counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= PC_RESET;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            cnt_q         <= 2'd0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q <= pc_d;
            if (bus.redirect_valid) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                cnt_q    <= 2'd0;
            end else begin
                if (push) wr_ptr_q <= ~wr_ptr_q;
                if (pop)  rd_ptr_q <= ~rd_ptr_q;
                cnt_q <= cnt_q + 2'(push) - 2'(pop);
            end
            if (push) fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    // Queue storage; contents are don't-care while the occupancy says empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]  <= pc_q;
            ins_mem_q[wr_ptr_q] <= bus.imem_data;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.out_valid   = head_vld;
    assign bus.out_instr   = head_vld ? ins_mem_q[rd_ptr_q] : 32'd0;
    assign bus.out_pc      = head_vld ? pc_mem_q[rd_ptr_q]  : 32'd0;
    assign bus.halted      = halted;
    assign bus.fetch_count = fetch_count_q;
endmodule
